// File: rtl/vc_link_transmitter.sv
// Link-side reader for a bank of VC FIFOs: credit-gated round-robin pop,
// registered flit/VC-id onto the link, per-VC downstream credit tracking.
module vc_link_transmitter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_VC     = 4,
    parameter int CREDITS    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tx_en,
    input  logic [NUM_VC-1:0]            vc_empty,
    input  logic [NUM_VC*DATA_WIDTH-1:0] vc_rd_data,
    output logic [NUM_VC-1:0]            vc_rd_en,
    output logic                         link_valid,
    output logic [DATA_WIDTH-1:0]        link_data,
    output logic [2:0]                   link_vc,
    input  logic                         credit_in_valid,
    input  logic [2:0]                   credit_in_vc,
    output logic [NUM_VC-1:0]            credit_avail,
    output logic                         credit_err
);

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    logic [3:0]            r_credit [NUM_VC];
    logic [2:0]            r_rr_ptr;
    logic                  r_link_valid;
    logic [DATA_WIDTH-1:0] r_link_data;
    logic [2:0]            r_link_vc;
    logic                  r_credit_err;

    logic [7:0]            w_eligible;
    logic                  w_grant_valid;
    logic [2:0]            w_grant_idx;
    logic [NUM_VC-1:0]     w_inc;
    logic [NUM_VC-1:0]     w_dec;
    logic [3:0]            w_credit_nxt [NUM_VC];
    logic                  w_full_hit;
    logic                  w_bad_vc;
    logic                  w_err_set;

    // Modular increment of a VC index within 0..NUM_VC-1.
    function automatic logic [2:0] wrap_add(input logic [2:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        while (sum >= NUM_VC)
            sum = sum - NUM_VC;
        return sum[2:0];
    endfunction

    // Eligibility is padded to 8 bits so any 3-bit VC index selects a defined bit.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_eligible[i] = !vc_empty[i] && (r_credit[i] != 4'd0);
        end
    end

    // NOTE: every signal written in an always_comb gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 3'd0;
        if (tx_en && !rst) begin
            for (int k = 0; k < NUM_VC; k++) begin
                if (!w_grant_valid && w_eligible[wrap_add(r_rr_ptr, unsigned'(k))]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = wrap_add(r_rr_ptr, unsigned'(k));
                end
            end
        end
    end

    always_comb begin
        vc_rd_en = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            vc_rd_en[i] = w_grant_valid && (w_grant_idx == 3'(i));
        end
    end

    // A grant and a return on the same VC cancel; a return at full count saturates.
    always_comb begin
        w_full_hit = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_inc[i]        = credit_in_valid && (credit_in_vc == 3'(i));
            w_dec[i]        = w_grant_valid && (w_grant_idx == 3'(i));
            w_credit_nxt[i] = r_credit[i];
            if (w_inc[i] && !w_dec[i]) begin
                if (r_credit[i] == CRED_MAX)
                    w_full_hit = 1'b1;
                else
                    w_credit_nxt[i] = r_credit[i] + 4'd1;
            end else if (w_dec[i] && !w_inc[i]) begin
                w_credit_nxt[i] = r_credit[i] - 4'd1;
            end
        end
        w_bad_vc  = credit_in_valid && (int'(credit_in_vc) >= NUM_VC);
        w_err_set = w_full_hit || w_bad_vc;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VC; i++)
                r_credit[i] <= CRED_MAX;
            r_rr_ptr     <= 3'd0;
            r_link_valid <= 1'b0;
            r_link_data  <= '0;
            r_link_vc    <= 3'd0;
            r_credit_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++)
                r_credit[i] <= w_credit_nxt[i];
            r_link_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_link_data <= vc_rd_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                r_link_vc   <= w_grant_idx;
                r_rr_ptr    <= wrap_add(w_grant_idx, 1);
            end
            if (w_err_set)
                r_credit_err <= 1'b1;
        end
    end

    always_comb begin
        credit_avail = '0;
        for (int i = 0; i < NUM_VC; i++)
            credit_avail[i] = (r_credit[i] != 4'd0);
    end

    assign link_valid = r_link_valid;
    assign link_data  = r_link_data;
    assign link_vc    = r_link_vc;
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_vc_link_transmitter.sv
// Scoreboard bench: a credit/queue-level reference predicts each pop and link flit;
// a separate monitor compares link outputs against the expected-flit queue.
module tb_vc_link_transmitter;

    localparam int DW = 32;
    localparam int NV = 4;
    localparam int CR = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [2:0]    vc;
    } flit_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              tx_en;
    logic [NV-1:0]     vc_empty;
    logic [NV*DW-1:0]  vc_rd_data;
    logic [NV-1:0]     vc_rd_en;
    logic              link_valid;
    logic [DW-1:0]     link_data;
    logic [2:0]        link_vc;
    logic              credit_in_valid;
    logic [2:0]        credit_in_vc;
    logic [NV-1:0]     credit_avail;
    logic              credit_err;

    always #5 clk = ~clk;

    vc_link_transmitter #(.DATA_WIDTH(DW), .NUM_VC(NV), .CREDITS(CR)) dut (
        .clk            (clk),
        .rst            (rst),
        .tx_en          (tx_en),
        .vc_empty       (vc_empty),
        .vc_rd_data     (vc_rd_data),
        .vc_rd_en       (vc_rd_en),
        .link_valid     (link_valid),
        .link_data      (link_data),
        .link_vc        (link_vc),
        .credit_in_valid(credit_in_valid),
        .credit_in_vc   (credit_in_vc),
        .credit_avail   (credit_avail),
        .credit_err     (credit_err)
    );

    int checks = 0;
    int errors = 0;

    // Local VC FIFOs (environment) and reference state.
    logic [DW-1:0] fmem [NV][256];
    int            fwr [NV];
    int            frd [NV];
    int            m_credit [NV];
    int            outstanding [NV];
    int            m_ptr;
    bit            m_err;
    flit_t         sb [$];
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int fcount(input int v);
        return fwr[v] - frd[v];
    endfunction

    task automatic push_flit(input int v);
        fmem[v][fwr[v] % 256] = $urandom;
        fwr[v]++;
    endtask

    task automatic clear_fifos();
        for (int v = 0; v < NV; v++) frd[v] = fwr[v];
    endtask

    task automatic update_view();
        for (int v = 0; v < NV; v++) begin
            vc_empty[v]           = (fcount(v) == 0);
            vc_rd_data[v*DW +: DW] = fmem[v][frd[v] % 256];
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_credit[v]    = CR;
            outstanding[v] = 0;
        end
        m_ptr = 0;
        m_err = 1'b0;
        sb.delete();
    endtask

    // One clock: drive inputs, predict and check the pop, then advance the reference.
    task automatic cycle(input bit rv, input bit tv, input bit cv, input int cvc);
        int            g;
        logic [NV-1:0] exp_rd;
        logic [NV-1:0] exp_av;
        @(negedge clk);
        rst             = rv;
        tx_en           = tv;
        credit_in_valid = cv;
        credit_in_vc    = 3'(cvc);
        update_view();
        #1;
        g = -1;
        if (!rv && tv) begin
            for (int k = 0; k < NV; k++) begin
                int c = (m_ptr + k) % NV;
                if (g < 0 && fcount(c) > 0 && m_credit[c] > 0) g = c;
            end
        end
        exp_rd = '0;
        if (g >= 0) exp_rd[g] = 1'b1;
        exp_av = '0;
        for (int v = 0; v < NV; v++) exp_av[v] = (m_credit[v] > 0);
        check("vc_rd_en", 64'(vc_rd_en), 64'(exp_rd));
        check("credit_avail", 64'(credit_avail), 64'(exp_av));
        check("credit_err", 64'(credit_err), 64'(m_err));
        @(posedge clk);
        if (rv) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                sb.push_back('{data: fmem[g][frd[g] % 256], vc: 3'(g)});
                frd[g]++;
                m_credit[g]--;
                outstanding[g]++;
                m_ptr = (g + 1) % NV;
            end
            if (cv) begin
                if (cvc >= NV) m_err = 1'b1;
                else if (m_credit[cvc] == CR) m_err = 1'b1;
                else begin
                    m_credit[cvc]++;
                    if (outstanding[cvc] > 0) outstanding[cvc]--;
                end
            end
        end
    endtask

    task automatic return_all();
        for (int v = 0; v < NV; v++)
            while (outstanding[v] > 0) cycle(0, 0, 1, v);
    endtask

    // Monitor: the flit granted at posedge t must be on the link at negedge after t+1.
    initial begin
        flit_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("link_valid", 64'(link_valid), 64'(sb.size() > 0));
                if (link_valid && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("link_data", 64'(link_data), 64'(e.data));
                    check("link_vc", 64'(link_vc), 64'(e.vc));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; tx_en = 1'b0; credit_in_valid = 1'b0; credit_in_vc = 3'd0;
        vc_empty = '1; vc_rd_data = '0;
        for (int v = 0; v < NV; v++) begin fwr[v] = 0; frd[v] = 0; end
        model_reset();
        @(posedge clk);
        mon_en = 1'b1;

        // Reset held two cycles with every VC non-empty.
        for (int v = 0; v < NV; v++) push_flit(v);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);

        // Round-robin across all VCs, then with VC2 empty.
        for (int v = 0; v < NV; v++) begin push_flit(v); push_flit(v); end
        repeat (14) cycle(0, 1, 0, 0);
        return_all();
        for (int v = 0; v < NV; v++) if (v != 2) begin push_flit(v); push_flit(v); end
        repeat (8) cycle(0, 1, 0, 0);
        return_all();

        // Credit exhaustion on VC1, then a single return releases one more flit.
        cycle(1, 0, 0, 0);
        clear_fifos();
        repeat (6) push_flit(1);
        repeat (7) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 1);
        repeat (4) cycle(0, 1, 0, 0);

        // Grant and credit return on VC0 in the same cycle.
        cycle(1, 0, 0, 0);
        clear_fifos();
        repeat (3) push_flit(0);
        repeat (4) cycle(0, 1, 0, 0);
        push_flit(0);
        cycle(0, 1, 1, 0);
        push_flit(0); push_flit(1);
        repeat (3) cycle(0, 1, 0, 0);

        // Credit errors: overflow on VC3, then out-of-range VC id.
        cycle(1, 0, 0, 0);
        clear_fifos();
        cycle(0, 0, 1, 3);
        repeat (2) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 5);
        repeat (2) cycle(0, 0, 0, 0);

        // tx_en drop mid-stream, then reset with a flit registered.
        cycle(1, 0, 0, 0);
        for (int v = 0; v < NV; v++) repeat (3) push_flit(v);
        repeat (3) cycle(0, 1, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        repeat (2) cycle(0, 0, 0, 0);

        // Randomized traffic with legal credit returns and rare errors/resets.
        repeat (400) begin
            bit rv, tv, cv;
            int cvc;
            rv = ($urandom_range(99) < 2);
            tv = ($urandom_range(9) != 0);
            for (int v = 0; v < NV; v++)
                if (fcount(v) < 6 && $urandom_range(2) == 0) push_flit(v);
            cvc = $urandom_range(NV - 1);
            cv  = !rv && outstanding[cvc] > 0 && $urandom_range(1) == 1;
            if (!rv && $urandom_range(99) == 0) begin
                cv  = 1'b1;
                cvc = $urandom_range(7, NV);
            end
            cycle(rv, tv, cv, cvc);
        end

        repeat (3) cycle(0, 0, 0, 0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_link_transmitter.md
Name: vc_link_transmitter

Overview:
Output-side reader for a router port's bank of virtual_channel FIFOs.
- Each cycle, picks one non-empty VC that holds a downstream credit, using round-robin arbitration.
- Pops that VC and drives the flit onto the inter-router link, tagged with its VC id.
- Tracks per-VC credits for the downstream receiver's buffers, replenished by credit-return pulses from the neighbour.

Parameters:
DATA_WIDTH, 32, flit width in bits
NUM_VC, 4, number of virtual channels served (2..8)
CREDITS, 4, downstream buffer depth per VC; initial credit count (1..15)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
tx_en  input  1  1 = arbitration enabled; 0 = no new grants
vc_empty  input  NUM_VC  empty flag per local VC FIFO
vc_rd_data  input  NUM_VC*DATA_WIDTH  head flit per VC; VC i at bits [i*DATA_WIDTH +: DATA_WIDTH]
vc_rd_en  output  NUM_VC  one-hot pop strobe to local VC FIFOs (combinational)
link_valid  output  1  flit present on link this cycle (registered)
link_data  output  DATA_WIDTH  flit payload (registered)
link_vc  output  3  VC id of flit (registered)
credit_in_valid  input  1  downstream freed one slot
credit_in_vc  input  3  VC id of returned credit
credit_avail  output  NUM_VC  bit i = credit count of VC i > 0
credit_err  output  1  sticky: credit returned to VC already holding CREDITS

Behaviour:
- Interface fixed: one clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at posedge):
  - all credit counters = CREDITS
  - rr_ptr = 0
  - link_valid = 0, link_data = 0, link_vc = 0
  - credit_err = 0
  - vc_rd_en is forced 0 while rst=1.
- Eligibility: VC i is eligible when vc_empty[i]=0 and credit[i]>0.
- Arbitration (combinational):
  - Active only when tx_en=1 and rst=0.
  - Searches i = rr_ptr, rr_ptr+1, ... mod NUM_VC; first eligible VC wins (grant g).
  - No eligible VC means no grant.
- On grant g:
  - vc_rd_en[g]=1 in the same cycle; all other bits 0; at most one bit set.
  - At posedge: link_data <= vc_rd_data[g]; link_vc <= g; link_valid <= 1; credit[g] decrements; rr_ptr <= (g+1) mod NUM_VC.
- No grant: link_valid <= 0 at posedge; link_data and link_vc hold their previous values; rr_ptr holds.
- Latency: flit appears on the link exactly 1 cycle after its pop. Sustained throughput is 1 flit/cycle.
- link_valid is a single-cycle qualifier. There is no ready signal; downstream space is guaranteed by credits.
- Credit return: credit_in_valid=1 increments credit[credit_in_vc] at posedge.
  - Grant to the same VC in the same cycle: net count unchanged.
  - Return to VC with count == CREDITS and no simultaneous grant to it: count saturates at CREDITS and credit_err <= 1.
  - credit_in_vc >= NUM_VC: return ignored and credit_err <= 1.
  - credit_err clears only on rst.
- Credit counters are 4 bits wide. A grant is never issued at count 0, so counters cannot underflow.
- credit_avail is combinational from the current counters.
- tx_en=0: no pops. A flit already registered still completes its valid cycle. Credit returns are still accepted.
- Reset mid-stream: a flit registered but not yet shown is discarded (link_valid=0 next cycle). Counters return to CREDITS; the downstream receiver is reset together with this block.

Test Plan:
- Reset: hold rst 2 cycles with all VCs non-empty -> vc_rd_en=0, link_valid=0, credit_avail=4'b1111, credit_err=0.
- Credit exhaustion: VC1 only non-empty, flits A1..A6, no credit returns -> 4 pops, link carries A1..A4 with link_vc=1 on consecutive cycles. Then link_valid=0 and credit_avail[1]=0. One credit return on VC1 -> A5 is sent 2 cycles later.
- Round-robin: all 4 VCs non-empty, ample credits -> link_vc sequence 0,1,2,3,0,1. With VC2 empty -> sequence 0,1,3,0,1,3.
- Simultaneous events: VC0 holds 1 credit, grant to VC0 and credit return to VC0 in the same cycle -> count stays 1, and VC0 is granted again when the pointer returns.
- Credit error: return a credit to VC3 at full count 4 -> count stays 4 and credit_err=1 until rst. Return with credit_in_vc=5 -> also sets credit_err.
- tx_en and mid-stream reset: drop tx_en during streaming -> last flit still valid for 1 cycle, then no pops. Assert rst while a flit is registered -> link_valid=0 next cycle and all credits restored to 4.
